bbus_reader: RTL and testbench
==============================

BBUS_READER -- requirements
Module: bbus_reader

Interface
REQ-001 SHALL have parameter NUM_GPR, default 8: number of general purpose register sources.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles spent waiting for mem_valid.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rd_req, input, 1 bit: B-bus read request, one-cycle pulse from the microinstruction.
REQ-006 SHALL have port rd_sel, input, 4 bits: source select; 0..NUM_GPR-1 selects a GPR, 8 selects memory, 9..15 are invalid.
REQ-007 SHALL have port gpr_in, input, 16*NUM_GPR bits: flattened GPR outputs; GPR k occupies bits [16k+15:16k].
REQ-008 SHALL have port mem_data, input, 16 bits: memory read data.
REQ-009 SHALL have port mem_valid, input, 1 bit: mem_data is valid this cycle.
REQ-010 SHALL have port mem_rd, output, 1 bit: one-cycle memory read strobe.
REQ-011 SHALL have port b_bus, output, 16 bits: registered B-bus value.
REQ-012 SHALL have port b_valid, output, 1 bit: one-cycle pulse marking that b_bus was updated this cycle.
REQ-013 SHALL have port busy, output, 1 bit: high while a memory read is outstanding.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse for an invalid select or a timeout.

Function
REQ-015 SHALL implement the states IDLE and MEM_WAIT.
REQ-016 In IDLE, a rd_req with rd_sel < NUM_GPR SHALL, on the next edge, load b_bus with the selected GPR slice and pulse b_valid; latency is 1 cycle.
REQ-017 In IDLE, back-to-back rd_req GPR reads SHALL be accepted every cycle, each producing its own b_valid.
REQ-018 In IDLE, a rd_req with rd_sel == 8 SHALL pulse mem_rd for exactly one cycle, raise busy and enter MEM_WAIT.
REQ-019 In IDLE, a rd_req with rd_sel in 9..15, or in NUM_GPR..7 when NUM_GPR < 8, SHALL pulse err on the next edge, with b_bus unchanged and b_valid low.
REQ-020 In MEM_WAIT, mem_valid SHALL load b_bus from mem_data, pulse b_valid, clear busy and return to IDLE on that edge.
REQ-021 In MEM_WAIT, a wait counter SHALL count cycles from 1; if it reaches MEM_TIMEOUT without mem_valid, err SHALL pulse, b_bus SHALL hold, busy SHALL clear and the state SHALL return to IDLE.
REQ-022 If mem_valid and timeout occur in the same cycle, the data SHALL win: b_valid pulses and err stays low.
REQ-023 rd_req arriving while busy SHALL be ignored (no queuing, no err).
REQ-024 mem_valid arriving in IDLE SHALL be ignored.
REQ-025 b_bus SHALL hold its last value whenever b_valid is low.
REQ-026 b_valid and err SHALL never be high in the same cycle.

Reset
REQ-027 rst SHALL set the state to IDLE and clear b_bus to 16'h0000, b_valid, err, mem_rd, busy and the wait counter on the next clk edge.
REQ-028 rst asserted during MEM_WAIT SHALL abort the read; a mem_valid arriving afterwards SHALL be ignored.
REQ-029 rst SHALL take priority over rd_req and mem_valid in the same cycle.

Structure
REQ-030 The shared package bbus_pkg SHALL hold the state enumeration, the constant SEL_MEM = 4'd8, and the bus width constant 16.
REQ-031 The wait counter SHALL be a separate sub-module, wait_timer (ports: clk, rst, start, clear, expired), sized from MEM_TIMEOUT.
REQ-032 No combinational path SHALL exist from any input to b_bus or b_valid.

Verification
REQ-033 Scenario: reset, then rd_req with rd_sel=3 and GPR3=16'hA5A5 -> next cycle b_bus=16'hA5A5, b_valid=1 for 1 cycle.
REQ-034 Scenario: rd_req on three consecutive cycles with sel 0,1,2 holding 16'h0001/16'h0002/16'h0003 -> b_bus 1,2,3 on consecutive cycles, b_valid high for 3 cycles.
REQ-035 Scenario: rd_sel=8 -> mem_rd pulse and busy=1; mem_valid after 4 cycles with 16'h1234 -> b_bus=16'h1234, b_valid pulse, busy=0; a rd_req sent during the wait is ignored.
REQ-036 Scenario: rd_sel=8 and no mem_valid -> err pulse after 15 cycles, b_bus unchanged, busy=0; a repeat with mem_valid on cycle 15 -> b_valid only.
REQ-037 Scenario: rd_sel=12 -> err pulse, b_valid=0, b_bus unchanged.
REQ-038 Scenario: rst asserted mid MEM_WAIT, then a late mem_valid -> b_bus=16'h0000, busy=0, no b_valid.

Source files
------------

// File: rtl/bbus_pkg.sv
// Shared types and constants for the B-bus reader: bus width, the memory
// source select code and the controller state encoding.
package bbus_pkg;

   localparam int BUS_W = 16;
   localparam logic [3:0] SEL_MEM = 4'd8;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // A select addresses a GPR only below both the populated GPR count and the memory code.
   function automatic logic sel_is_gpr(input logic [3:0] sel, input int num_gpr);
      return ({28'd0, sel} < 32'(num_gpr)) && (sel < SEL_MEM);
   endfunction

endpackage

// File: rtl/bbus_reader_wait_timer.sv
// Memory wait counter: loads 1 on start, counts once per cycle and saturates
// at TIMEOUT, where expired stays high until clear or reset.
module wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // A count of zero means idle, so the first waiting cycle reads as 1.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (start) begin
         count <= CW'(1);
      end else if ((count != '0) && (count < LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/bbus_reader.sv
// B-bus source reader: returns a GPR in one cycle or fetches a memory word
// with a bounded wait, reporting invalid selects and timeouts on err.
module bbus_reader
   import bbus_pkg::*;
#(
   parameter int NUM_GPR     = 8,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_req,
   input  logic [3:0]               rd_sel,
   input  logic [BUS_W*NUM_GPR-1:0] gpr_in,
   input  logic [BUS_W-1:0]         mem_data,
   input  logic                     mem_valid,
   output logic                     mem_rd,
   output logic [BUS_W-1:0]         b_bus,
   output logic                     b_valid,
   output logic                     busy,
   output logic                     err
);

   state_t           state;
   state_t           next_state;
   logic [BUS_W-1:0] gpr_word;
   logic [BUS_W-1:0] b_bus_d;
   logic             b_valid_d;
   logic             err_d;
   logic             mem_rd_d;
   logic             tmr_start;
   logic             tmr_clear;
   logic             tmr_expired;

   wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (tmr_start),
      .clear   (tmr_clear),
      .expired (tmr_expired)
   );

   always_comb begin
      gpr_word = '0;
      for (int k = 0; k < NUM_GPR; k++) begin
         if (rd_sel == 4'(k)) begin
            gpr_word = gpr_in[BUS_W*k +: BUS_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Data beats a same-cycle timeout, so mem_valid is tested before expiry.
   always_comb begin
      next_state = state;
      b_bus_d    = b_bus;
      b_valid_d  = 1'b0;
      err_d      = 1'b0;
      mem_rd_d   = 1'b0;
      tmr_start  = 1'b0;
      tmr_clear  = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) begin
               if (sel_is_gpr(rd_sel, NUM_GPR)) begin
                  b_bus_d   = gpr_word;
                  b_valid_d = 1'b1;
               end else if (rd_sel == SEL_MEM) begin
                  mem_rd_d   = 1'b1;
                  tmr_start  = 1'b1;
                  next_state = MEM_WAIT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         MEM_WAIT: begin
            if (mem_valid) begin
               b_bus_d    = mem_data;
               b_valid_d  = 1'b1;
               tmr_clear  = 1'b1;
               next_state = IDLE;
            end else if (tmr_expired) begin
               err_d      = 1'b1;
               tmr_clear  = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // All outputs are registered so no input reaches b_bus or b_valid combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_bus   <= '0;
         b_valid <= 1'b0;
         err     <= 1'b0;
         mem_rd  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         b_bus   <= b_bus_d;
         b_valid <= b_valid_d;
         err     <= err_d;
         mem_rd  <= mem_rd_d;
         busy    <= (next_state == MEM_WAIT);
      end
   end

endmodule

// File: tb/tb_bbus_reader.sv
// Directed self-checking bench for bbus_reader with default parameters.
module tb_bbus_reader;

   logic         clk;
   logic         rst;
   logic         rd_req;
   logic [3:0]   rd_sel;
   logic [127:0] gpr_in;
   logic [15:0]  mem_data;
   logic         mem_valid;
   logic         mem_rd;
   logic [15:0]  b_bus;
   logic         b_valid;
   logic         busy;
   logic         err;

   int checks;
   int errors;

   bbus_reader #(
      .NUM_GPR     (8),
      .MEM_TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_req    (rd_req),
      .rd_sel    (rd_sel),
      .gpr_in    (gpr_in),
      .mem_data  (mem_data),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .b_bus     (b_bus),
      .b_valid   (b_valid),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic [3:0] sel,
                                input logic mv, input logic [15:0] md);
      rd_req    = req;
      rd_sel    = sel;
      mem_valid = mv;
      mem_data  = md;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Checks every output against one expected snapshot.
   task automatic checkAll(input string tag, input logic [15:0] e_bus, input logic e_valid,
                           input logic e_err, input logic e_busy, input logic e_mem_rd);
      checkOutput({tag, "_b_bus"}, b_bus, e_bus);
      checkOutput({tag, "_b_valid"}, {15'd0, b_valid}, {15'd0, e_valid});
      checkOutput({tag, "_err"}, {15'd0, err}, {15'd0, e_err});
      checkOutput({tag, "_busy"}, {15'd0, busy}, {15'd0, e_busy});
      checkOutput({tag, "_mem_rd"}, {15'd0, mem_rd}, {15'd0, e_mem_rd});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      gpr_in = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                16'hA5A5, 16'h0003, 16'h0002, 16'h0001};
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      rst = 1'b1;
      nextCycle();
      nextCycle();
      rst = 1'b0;
      checkAll("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single GPR read, one-cycle latency
      applyStimulus(1'b1, 4'd3, 1'b0, 16'h0000);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("gpr3", 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkAll("gpr3_after", 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back GPR reads
      applyStimulus(1'b1, 4'd0, 1'b0, 16'h0000);
      nextCycle();
      checkAll("b2b_0", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd1, 1'b0, 16'h0000);
      nextCycle();
      checkAll("b2b_1", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 1'b0, 16'h0000);
      nextCycle();
      checkAll("b2b_2", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      nextCycle();
      checkAll("b2b_end", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

      // Memory read answered on wait cycle 5; GPR request during the wait is dropped
      applyStimulus(1'b1, 4'd8, 1'b0, 16'h0000);
      nextCycle();
      applyStimulus(1'b1, 4'd0, 1'b0, 16'h0000);
      checkAll("mem_c1", 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("mem_c2", 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
      nextCycle();
      nextCycle();
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b1, 16'h1234);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("mem_data", 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkAll("mem_after", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

      // Stray mem_valid in IDLE
      applyStimulus(1'b0, 4'd0, 1'b1, 16'hBEEF);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("idle_mv", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

      // Timeout after 15 wait cycles
      applyStimulus(1'b1, 4'd8, 1'b0, 16'h0000);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      for (int i = 0; i < 14; i++) nextCycle();
      checkAll("to_c15", 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
      nextCycle();
      checkAll("to_err", 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      checkAll("to_after", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

      // Data arriving on wait cycle 15 beats the timeout
      applyStimulus(1'b1, 4'd8, 1'b0, 16'h0000);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      for (int i = 0; i < 14; i++) nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b1, 16'h5678);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("race", 16'h5678, 1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkAll("race_after", 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);

      // Invalid select
      applyStimulus(1'b1, 4'd12, 1'b0, 16'h0000);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("bad_sel", 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      checkAll("bad_after", 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during MEM_WAIT, then a late mem_valid
      applyStimulus(1'b1, 4'd8, 1'b0, 16'h0000);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      nextCycle();
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      checkAll("rst_wait", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b1, 16'h9999);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("late_mv", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset wins over a simultaneous request
      rst = 1'b1;
      applyStimulus(1'b1, 4'd3, 1'b0, 16'h0000);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0, 16'h0000);
      checkAll("rst_prio", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
